// File: rtl/if_id_skid.sv
// IF->ID pipeline stage with a main/skid register pair: ready/valid handshake on both sides,
// stall/flush control and saturating stall/flush event counters.
module if_id_skid #(
  parameter int unsigned       INST_W       = 32,
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [INST_W-1:0] NOP_INST     = 32'h0000_0013,
  parameter bit                FLUSH_BUBBLE = 1'b1,
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] instr_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [INST_W-1:0]   main_instr_q, main_instr_d;
  logic [ADDR_W-1:0]   main_pc_q, main_pc_d;
  logic [INST_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;
  logic                acc, deq;

  // Ready depends only on registered state and control inputs, never on out_ready_i.
  assign in_ready_o  = ~rst_i & ~stall_i & (state_q != FULL);
  assign out_valid_o = ~stall_i & (state_q != EMPTY);
  assign acc         = in_valid_i & in_ready_o;
  assign deq         = out_valid_o & out_ready_i;

  assign instr_o     = main_instr_q;
  assign pc_o        = main_pc_q;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (!stall_i) begin
      if (flush_i) begin
        if (FLUSH_BUBBLE) begin
          state_d      = ONE;
          main_instr_d = NOP_INST;
          main_pc_d    = '0;
        end else begin
          state_d = EMPTY;
        end
      end else begin
        case (state_q)
          EMPTY: begin
            if (acc) begin
              state_d      = ONE;
              main_instr_d = instr_i;
              main_pc_d    = pc_i;
            end
          end
          ONE: begin
            if (acc && deq) begin
              main_instr_d = instr_i;
              main_pc_d    = pc_i;
            end else if (acc) begin
              state_d      = FULL;
              skid_instr_d = instr_i;
              skid_pc_d    = pc_i;
            end else if (deq) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            // The skid beat is always younger, so it moves up into the head slot.
            if (deq) begin
              state_d      = ONE;
              main_instr_d = skid_instr_q;
              main_pc_d    = skid_pc_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      main_instr_q <= NOP_INST;
      main_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      if (stall_i && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (flush_i && !stall_i && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// Randomised scoreboard bench for if_id_skid: a bubble-inserting 16-bit-counter instance and an
// emptying 2-bit-counter instance share stimulus, each checked against a queue-level model.
module tb_if_id_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, flush, in_valid, out_ready;
  logic [31:0] instr, pc, pc_next;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] instr_a, pc_a, instr_b, pc_b;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  if_id_skid dut_a (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready), .instr_o(instr_a), .pc_o(pc_a),
    .occupancy_o(occ_a), .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
  );

  if_id_skid #(.FLUSH_BUBBLE(1'b0), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .instr_i(instr), .pc_i(pc),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready), .instr_o(instr_b), .pc_o(pc_b),
    .occupancy_o(occ_b), .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
  );

  logic        d_in_ready[2], d_out_valid[2];
  logic [31:0] d_instr[2], d_pc[2], d_stall_cnt[2], d_flush_cnt[2];
  logic [1:0]  d_occ[2];
  assign d_in_ready[0] = in_ready_a;   assign d_in_ready[1] = in_ready_b;
  assign d_out_valid[0] = out_valid_a; assign d_out_valid[1] = out_valid_b;
  assign d_instr[0] = instr_a;         assign d_instr[1] = instr_b;
  assign d_pc[0] = pc_a;               assign d_pc[1] = pc_b;
  assign d_occ[0] = occ_a;             assign d_occ[1] = occ_b;
  assign d_stall_cnt[0] = {16'd0, stall_cnt_a};
  assign d_stall_cnt[1] = {30'd0, stall_cnt_b};
  assign d_flush_cnt[0] = {16'd0, flush_cnt_a};
  assign d_flush_cnt[1] = {30'd0, flush_cnt_b};

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Expected-beat queues (index 0 is the head) plus raw event counts per instance.
  logic [31:0] exp_instr[2][$];
  logic [31:0] exp_pc[2][$];
  int          m_stall[2], m_flush[2];
  bit          m_fresh[2];
  int          vectors = 0;
  int          miscompares = 0;
  bit          check_en = 1'b0;

  function automatic int sat(input int cnt, input int l);
    int lim;
    lim = (l == 0) ? 65535 : 3;
    return (cnt > lim) ? lim : cnt;
  endfunction

  task automatic cmp(input string name, input int l, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d t=%0t: got %h expected %h", name, l, $time, act, exp);
    end
  endtask

  // Runs mid-cycle: compares what the DUTs present now, then advances the model across the next edge.
  task automatic checkOutput();
    for (int l = 0; l < 2; l++) begin
      bit exp_ready, exp_valid, acc, deq;
      int n;
      n         = exp_instr[l].size();
      exp_ready = !rst && !stall && (n < 2);
      exp_valid = !stall && (n > 0);
      cmp("in_ready", l, 32'(d_in_ready[l]), 32'(exp_ready));
      cmp("out_valid", l, 32'(d_out_valid[l]), 32'(exp_valid));
      cmp("occupancy", l, 32'(d_occ[l]), 32'(n));
      cmp("stall_cnt", l, d_stall_cnt[l], 32'(sat(m_stall[l], l)));
      cmp("flush_cnt", l, d_flush_cnt[l], 32'(sat(m_flush[l], l)));
      if (exp_valid) begin
        cmp("head_instr", l, d_instr[l], exp_instr[l][0]);
        cmp("head_pc", l, d_pc[l], exp_pc[l][0]);
      end else if (m_fresh[l] && n == 0) begin
        cmp("reset_instr", l, d_instr[l], NOP);
        cmp("reset_pc", l, d_pc[l], 32'd0);
      end
      acc = in_valid && exp_ready;
      deq = exp_valid && out_ready;
      if (rst) begin
        exp_instr[l].delete();
        exp_pc[l].delete();
        m_stall[l] = 0;
        m_flush[l] = 0;
        m_fresh[l] = 1'b1;
      end else if (stall) begin
        m_stall[l]++;
      end else if (flush) begin
        m_flush[l]++;
        exp_instr[l].delete();
        exp_pc[l].delete();
        if (l == 0) begin
          exp_instr[l].push_back(NOP);
          exp_pc[l].push_back(32'd0);
        end
        m_fresh[l] = 1'b0;
      end else begin
        if (deq) begin
          void'(exp_instr[l].pop_front());
          void'(exp_pc[l].pop_front());
        end
        if (acc) begin
          exp_instr[l].push_back(instr);
          exp_pc[l].push_back(pc);
          m_fresh[l] = 1'b0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  task automatic applyStimulus(input bit r, input bit s, input bit f, input bit v, input bit rd);
    rst       = r;
    stall     = s;
    flush     = f;
    in_valid  = v;
    out_ready = rd;
    instr     = $urandom;
    pc        = pc_next;
    pc_next   = pc_next + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; pc = '0; pc_next = '0;
    for (int l = 0; l < 2; l++) begin
      m_stall[l] = 0; m_flush[l] = 0; m_fresh[l] = 1'b1;
    end
    applyStimulus(1, 0, 0, 0, 0);
    check_en = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    pc_next = 32'h0;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1);
    pc_next = 32'h10;
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 60);
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
